rns_to_bin_seq: RTL and testbench

//  Converts an N-digit RNS word (residue digits as produced by the digmod reducers) back to binary.

---
 rtl/rns_pkg.sv | 26 ++
 rtl/rns_to_bin_seq_if.sv | 27 ++
 rtl/modmul_shift_add.sv | 65 ++++++
 rtl/rns_to_bin_seq.sv | 107 ++++++++++
 tb/tb_rns_to_bin_seq.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/rns_pkg.sv
// Shared RNS constants for the residue-to-binary converter: default moduli,
// precomputed pairwise inverses and the converter state encoding.
package rns_pkg;

    localparam int RNS_N  = 3;
    localparam int RNS_DW = 18;

    // Ascending moduli, so every earlier mixed-radix digit is below every later modulus.
    localparam logic [RNS_N*RNS_DW-1:0] RNS_MODULI = {18'd262143, 18'd262141, 18'd262139};

    // Field (j*N+i) holds inv(m_j mod m_i) mod m_i; only i>j entries are meaningful.
    localparam logic [RNS_N*RNS_N*RNS_DW-1:0] RNS_MINV = {
        18'd0, 18'd0, 18'd0,
        18'd131071, 18'd0, 18'd0,
        18'd196607, 18'd131070, 18'd0
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SUB,
        ST_MUL,
        ST_RECON,
        ST_DONE
    } state_e;

endpackage

// File: rtl/rns_to_bin_seq_if.sv
// Valid/ready bus carrying residue words in and binary results out.
interface rns_to_bin_seq_if
    import rns_pkg::*;
#(
    parameter int N         = RNS_N,
    parameter int DW        = RNS_DW,
    parameter int OUT_WIDTH = N * DW
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [N*DW-1:0]      res_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] bin_out;

    modport master (
        output in_valid, res_in, out_ready,
        input  in_ready, out_valid, bin_out
    );

    modport slave (
        input  in_valid, res_in, out_ready,
        output in_ready, out_valid, bin_out
    );

endinterface

// File: rtl/modmul_shift_add.sv
// Sequential (a*b) mod m, one bit of b per cycle MSB-first; the first step
// happens on the start edge so the result is ready exactly DW cycles later.
module modmul_shift_add #(
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] m,
    output logic [DW-1:0] res,
    output logic          done
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    logic [DW:0]   acc, acc_in, dbl, dbl_r, add, add_r, nxt;
    logic [DW-1:0] a_reg, m_reg, b_sh, a_use, m_use;
    logic          bit_use, busy;
    logic [CW-1:0] cnt;

    always_comb begin
        acc_in  = start ? '0 : acc;
        a_use   = start ? a : a_reg;
        m_use   = start ? m : m_reg;
        bit_use = start ? b[DW-1] : b_sh[DW-1];
        // Both partial results stay below 2m, so one conditional subtract suffices.
        dbl     = acc_in + acc_in;
        dbl_r   = (dbl >= {1'b0, m_use}) ? dbl - {1'b0, m_use} : dbl;
        add     = dbl_r + {1'b0, a_use};
        add_r   = (add >= {1'b0, m_use}) ? add - {1'b0, m_use} : add;
        nxt     = bit_use ? add_r : dbl_r;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            a_reg <= '0;
            m_reg <= '0;
            b_sh  <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
        end else if (start) begin
            acc   <= nxt;
            a_reg <= a;
            m_reg <= m;
            b_sh  <= b << 1;
            busy  <= 1'b1;
            cnt   <= CW'(DW - 1);
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                acc  <= nxt;
                b_sh <= b_sh << 1;
                cnt  <= cnt - 1'b1;
            end
        end
    end

    assign res  = acc[DW-1:0];
    assign done = busy && (cnt == '0);

endmodule

// File: rtl/rns_to_bin_seq.sv
// RNS to binary converter: mixed-radix digits by iterative subtract/multiply,
// then Horner reconstruction. One word in flight, valid/ready both sides.
module rns_to_bin_seq
    import rns_pkg::*;
#(
    parameter int                   N         = RNS_N,
    parameter int                   DW        = RNS_DW,
    parameter int                   OUT_WIDTH = N * DW,
    parameter logic [N*DW-1:0]      MODULI    = RNS_MODULI,
    parameter logic [N*N*DW-1:0]    MINV      = RNS_MINV
) (
    input logic             clk,
    input logic             reset,
    rns_to_bin_seq_if.slave bus
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_e               state, state_nxt;
    logic [DW-1:0]        r [N];
    logic [IW-1:0]        i, j, k;
    logic [OUT_WIDTH-1:0] x;
    logic [DW-1:0]        m_i, m_k, minv_ji, d, mm_res;
    logic [DW:0]          diff;
    logic                 mm_start, mm_done, accept, last_pair;

    assign m_i     = MODULI[int'(i)*DW +: DW];
    assign m_k     = MODULI[int'(k)*DW +: DW];
    assign minv_ji = MINV[(int'(j)*N + int'(i))*DW +: DW];

    // r[j] < m_j < m_i, so a single add of m_i brings a negative difference into range.
    assign diff = {1'b0, r[i]} - {1'b0, r[j]};
    assign d    = diff[DW] ? DW'(diff + {1'b0, m_i}) : diff[DW-1:0];

    assign accept    = bus.in_valid && (state == ST_IDLE);
    assign last_pair = (i == IW'(N - 1)) && (j == IW'(N - 2));
    assign mm_start  = (state == ST_SUB);

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.bin_out   = x;

    modmul_shift_add #(.DW(DW)) u_mm (
        .clk   (clk),
        .reset (reset),
        .start (mm_start),
        .a     (d),
        .b     (minv_ji),
        .m     (m_i),
        .res   (mm_res),
        .done  (mm_done)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_SUB;
            ST_SUB:   state_nxt = ST_MUL;
            ST_MUL:   if (mm_done) state_nxt = last_pair ? ST_RECON : ST_SUB;
            ST_RECON: if (k == '0) state_nxt = ST_DONE;
            ST_DONE:  if (bus.out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < N; n++) r[n] <= '0;
            i <= '0;
            j <= '0;
            k <= '0;
            x <= '0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    for (int n = 0; n < N; n++) r[n] <= bus.res_in[n*DW +: DW];
                    j <= '0;
                    i <= IW'(1);
                end
                ST_MUL: if (mm_done) begin
                    r[i] <= mm_res;
                    if (last_pair) begin
                        k <= IW'(N - 1);
                    end else if (i == IW'(N - 1)) begin
                        j <= j + 1'b1;
                        i <= j + IW'(2);
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                // First RECON cycle loads the top digit, then one MAC per lower digit.
                ST_RECON: begin
                    if (k == IW'(N - 1)) x <= OUT_WIDTH'(r[N-1]);
                    else                 x <= x * OUT_WIDTH'(m_k) + OUT_WIDTH'(r[k]);
                    if (k != '0) k <= k - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rns_to_bin_seq.sv
// Bench for rns_to_bin_seq: small-moduli instance for directed and random
// traffic, default instance for full-width random values.
module tb_rns_to_bin_seq;
    import rns_pkg::*;

    localparam int TN = 3, TDW = 4, TOW = 12;
    localparam logic [TN*TDW-1:0]    T_MOD  = {4'd13, 4'd11, 4'd7};
    localparam logic [TN*TN*TDW-1:0] T_MINV = (36'd8 << 4) | (36'd2 << 8) | (36'd6 << 20);
    localparam int DOW = RNS_N * RNS_DW;
    localparam longint unsigned DM0 = longint'(RNS_MODULI[0*RNS_DW +: RNS_DW]);
    localparam longint unsigned DM1 = longint'(RNS_MODULI[1*RNS_DW +: RNS_DW]);
    localparam longint unsigned DM2 = longint'(RNS_MODULI[2*RNS_DW +: RNS_DW]);
    localparam longint unsigned D_PROD = DM0 * DM1 * DM2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rns_to_bin_seq_if #(.N(TN), .DW(TDW), .OUT_WIDTH(TOW)) t_if ();
    rns_to_bin_seq_if d_if ();

    rns_to_bin_seq #(.N(TN), .DW(TDW), .OUT_WIDTH(TOW), .MODULI(T_MOD), .MINV(T_MINV)) dut_t (
        .clk(clk), .reset(reset), .bus(t_if)
    );
    rns_to_bin_seq dut_d (
        .clk(clk), .reset(reset), .bus(d_if)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [TN*TDW-1:0] enc_t(input int x);
        return {4'(x % 13), 4'(x % 11), 4'(x % 7)};
    endfunction

    function automatic logic [DOW-1:0] enc_d(input longint unsigned x);
        return {18'(x % DM2), 18'(x % DM1), 18'(x % DM0)};
    endfunction

    task automatic run_t(input logic [TN*TDW-1:0] res, output logic [TOW-1:0] got, output int lat);
        @(negedge clk);
        t_if.res_in = res; t_if.in_valid = 1'b1; t_if.out_ready = 1'b1;
        @(negedge clk);
        t_if.in_valid = 1'b0;
        lat = 0;
        while (!t_if.out_valid && lat < 200) begin @(negedge clk); lat++; end
        got = t_if.bin_out;
        @(negedge clk);
    endtask

    task automatic run_d(input logic [DOW-1:0] res, output logic [DOW-1:0] got, output int lat);
        @(negedge clk);
        d_if.res_in = res; d_if.in_valid = 1'b1; d_if.out_ready = 1'b1;
        @(negedge clk);
        d_if.in_valid = 1'b0;
        lat = 0;
        while (!d_if.out_valid && lat < 300) begin @(negedge clk); lat++; end
        got = d_if.bin_out;
        @(negedge clk);
    endtask

    initial begin
        logic [TOW-1:0] got_t;
        logic [DOW-1:0] got_d;
        int lat, wait_cyc, sent, recv, cyc, cur_x;
        bit stable, pending, seen;
        int exp_q[$];
        longint unsigned xd;

        reset = 1'b1;
        t_if.in_valid = 1'b0; t_if.out_ready = 1'b0; t_if.res_in = '0;
        d_if.in_valid = 1'b0; d_if.out_ready = 1'b0; d_if.res_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_t_out_valid", t_if.out_valid, 0);
        check("rst_t_bin_out",   t_if.bin_out, 0);
        check("rst_t_in_ready",  t_if.in_ready, 1);
        check("rst_d_out_valid", d_if.out_valid, 0);
        check("rst_d_bin_out",   d_if.bin_out, 0);
        check("rst_d_in_ready",  d_if.in_ready, 1);

        // Basic conversion and fixed latency
        run_t({4'd6, 4'd5, 4'd3}, got_t, lat);
        check("t1_value", got_t, 500);
        check("t1_latency", lat, 18);

        run_t({4'd0, 4'd0, 4'd0}, got_t, lat);
        check("t2_zero", got_t, 0);
        run_t({4'd12, 4'd10, 4'd6}, got_t, lat);
        check("t2_max", got_t, 1000);
        check("t2_max_latency", lat, 18);
        run_t({4'd1, 4'd1, 4'd1}, got_t, lat);
        check("t2_one", got_t, 1);

        // Backpressure: stall 50 cycles with a competing input held valid
        @(negedge clk);
        t_if.res_in = {4'd6, 4'd5, 4'd3}; t_if.in_valid = 1'b1; t_if.out_ready = 1'b0;
        @(negedge clk);
        t_if.res_in = {4'd0, 4'd0, 4'd0};
        wait_cyc = 0;
        while (!t_if.out_valid && wait_cyc < 200) begin @(negedge clk); wait_cyc++; end
        check("t3_reach_done", t_if.out_valid, 1);
        stable = 1'b1;
        repeat (50) begin
            if (!(t_if.out_valid === 1'b1 && t_if.bin_out === 12'd500 && t_if.in_ready === 1'b0))
                stable = 1'b0;
            @(negedge clk);
        end
        check("t3_stall_stable", stable, 1);
        check("t3_stall_value", t_if.bin_out, 500);
        t_if.out_ready = 1'b1;
        @(negedge clk);
        check("t3_release_valid", t_if.out_valid, 0);
        check("t3_release_ready", t_if.in_ready, 1);
        t_if.in_valid = 1'b0;
        @(negedge clk);
        check("t3_no_accept", t_if.in_ready, 1);

        // Reset in the middle of a conversion
        t_if.res_in = {4'd12, 4'd10, 4'd6}; t_if.in_valid = 1'b1;
        @(negedge clk);
        t_if.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t4_out_valid", t_if.out_valid, 0);
        check("t4_in_ready", t_if.in_ready, 1);
        check("t4_bin_out", t_if.bin_out, 0);
        seen = 1'b0;
        repeat (25) begin
            if (t_if.out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("t4_no_partial", seen, 0);
        run_t({4'd6, 4'd5, 4'd3}, got_t, lat);
        check("t4_after_value", got_t, 500);
        check("t4_after_latency", lat, 18);

        // Random traffic with valid/ready gaps, scoreboard of expected values
        sent = 0; recv = 0; cyc = 0; pending = 1'b0; cur_x = 0;
        t_if.in_valid = 1'b0; t_if.out_ready = 1'b0;
        while ((sent < 1000 || recv < 1000) && cyc < 80000) begin
            @(negedge clk);
            cyc++;
            if (!pending && sent < 1000 && $urandom_range(0, 3) != 0) begin
                cur_x = int'($urandom_range(0, 1000));
                t_if.res_in = enc_t(cur_x);
                pending = 1'b1;
            end
            t_if.in_valid  = pending;
            t_if.out_ready = ($urandom_range(0, 2) != 0);
            if (t_if.in_valid && t_if.in_ready) begin
                exp_q.push_back(cur_x);
                sent++;
                pending = 1'b0;
            end
            if (t_if.out_valid && t_if.out_ready) begin
                if (exp_q.size() == 0) check("t5_extra_out", exp_q.size(), 1);
                else                   check("t5_data", t_if.bin_out, exp_q.pop_front());
                recv++;
            end
        end
        check("t5_sent", sent, 1000);
        check("t5_recv", recv, 1000);
        check("t5_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        t_if.in_valid = 1'b0; t_if.out_ready = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (t_if.out_valid) seen = 1'b1;
        end
        check("t5_no_dup", seen, 0);

        // Default-width instance, random values including both range ends
        for (int n = 0; n < 12; n++) begin
            if (n == 0)      xd = 0;
            else if (n == 1) xd = D_PROD - 1;
            else             xd = ((longint'($urandom) << 32) | longint'($urandom)) % D_PROD;
            run_d(enc_d(xd), got_d, lat);
            check("t6_value", got_d, xd);
            check("t6_latency", lat, 60);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
